seq_arbiter: RTL and testbench
==============================

// Module: seq_arbiter
// PURPOSE
// - Shares one seq_top engine (sequential multiply and divide) between NumReq requesters.
// - Uses round-robin arbitration. Only one operation is in flight at a time.
// - Accepts an operand pair per requester over valid/ready, pulses engine start,
//   and detects completion. Returns product/quotient/remainder over a per-requester response handshake.
// PARAMETERS
// - NumReq        4     number of requesters (>=1)
// - WidthA        32    multiplicand/dividend width
// - WidthB        32    multiplier/divisor width
// - TimeoutCycles 1024  max BUSY cycles before the op is aborted with error (>=2)
// - WidthC = WidthA+WidthB (localparam); IdW = $clog2(NumReq) min 1 (localparam)
// PORTS
// - clk_i        in   1                 clock, all state on rising edge
// - rst_ni       in   1                 reset, asynchronous, active-low
// - req_valid_i  in   NumReq            per-requester request valid
// - req_ready_o  out  NumReq            per-requester accept; one-hot or zero
// - req_a_i      in   NumReq x WidthA   packed operand a per requester
// - req_b_i      in   NumReq x WidthB   packed operand b per requester
// - rsp_valid_o  out  NumReq            response valid; one-hot or zero
// - rsp_ready_i  in   NumReq            response accept
// - rsp_c_o      out  WidthC            product (shared bus)
// - rsp_q_o      out  WidthA            quotient
// - rsp_r_o      out  WidthB            remainder
// - rsp_divz_o   out  1                 operand b was zero
// - rsp_err_o    out  1                 op aborted by timeout
// - eng_a_o      out  WidthA            engine operand a
// - eng_b_o      out  WidthB            engine operand b
// - eng_start_o  out  1                 engine start pulse
// - eng_c_i      in   WidthC            engine product
// - eng_q_i      in   WidthA            engine quotient
// - eng_r_i      in   WidthB            engine remainder
// - eng_finish_i in   1                 engine finish (level)
// - busy_o       out  1                 state != IDLE
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; rr pointer = 0; finish_d = 0.
// - Reset is asserted asynchronously, deasserted synchronously via the existing sync.
// - States: IDLE -> ISSUE -> BUSY -> RESP -> IDLE.
// - IDLE:
//   - Grant the first req_valid_i[k] at or after ptr, searching upward with wrap.
//   - req_ready_o[k] = 1 combinationally in the same cycle.
//   - On the handshake: latch a, b, id=k and divz=(b==0); ptr <= (k+1) mod NumReq; go to ISSUE.
//   - req_ready_o stays 0 in every other state.
// - ISSUE:
//   - eng_start_o = 1 for exactly one cycle.
//   - eng_a_o/eng_b_o come from the latched registers and are stable from ISSUE until the next grant.
//   - Clear the timer; go to BUSY.
// - BUSY:
//   - Completion = eng_finish_i & ~finish_d, i.e. a rising edge; finish_d is registered every cycle.
//   - A finish level already high at entry is never a completion.
//   - On completion: capture eng_c_i/q_i/r_i into response registers, err = 0, go to RESP.
//   - If the timer reaches TimeoutCycles-1 without completion: result regs = 0, err = 1, go to RESP.
//   - Completion and timeout in the same cycle: completion wins.
// - RESP:
//   - rsp_valid_o[id] = 1; rsp_* are registered and stable until rsp_ready_i[id].
//   - Then go to IDLE; a new grant is possible in the next cycle.
//   - rsp_ready_i bits other than id are ignored.
// - Latency: accept at T, start at T+1, response valid one cycle after the completion edge.
// - Requesters hold valid and operands until ready. Withdrawing before grant is tolerated, with no side effect.
// - Divide by zero: engine results pass through unchanged and rsp_divz_o = 1.
// - Reset mid-operation: the op is discarded without a response (the engine shares rst_ni).
// - NumReq = 1: ptr is constant 0.
// STRUCTURE
// - seq_pkg holds:
//   - typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} seq_arb_state_e
//   - width helper functions
// - Sub-module rr_arbiter (NumReq): inputs req and ptr, outputs one-hot gnt and binary gnt_id.
//   It is purely combinational; ptr is updated in seq_arbiter.
// - Top-level test wrapper instantiates seq_arbiter + seq_top; eng_* connect directly.
// TESTING
// - Single op: r0 a=6 b=3 -> start pulse at T+1; rsp_valid_o=0001, c=18 q=2 r=0, divz=0 err=0.
// - Fairness: all 4 valid continuously, a=100+i b=7 -> grant order 0,1,2,3,0.
//   Each response carries q=14,14,14,14 and r=2,3,4,5 on the matching bit.
// - Backpressure: rsp_ready_i low for 5 cycles -> rsp_* stable, req_ready_o=0, no start pulse; released -> IDLE.
// - Divide by zero: r2 a=5 b=0 -> c=0, rsp_divz_o=1, rsp_valid_o=0100.
// - Timeout: stub engine holds finish=1, TimeoutCycles=16.
//   After 16 BUSY cycles expect err=1, c=q=r=0; IDLE after rsp_ready.
// - Reset in BUSY: rst_ni low mid-op -> all outputs 0 immediately.
//   After release, r1 and r3 valid -> r1 granted first (ptr=0).

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and width helpers for the sequential-engine arbiter.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } seq_arb_state_e;

  // Index width for n items; at least one bit so a single requester still has a port.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

  // Full product width of an a x b multiply.
  function automatic int unsigned prod_width(input int unsigned wa, input int unsigned wb);
    return wa + wb;
  endfunction

endpackage

// File: rtl/seq_arbiter_rr.sv
// Combinational round-robin pick: first request at or above ptr, wrapping.
module rr_arbiter
  import seq_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdW   = id_width(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdW-1:0]    ptr,
  output logic [NumReq-1:0] gnt,
  output logic [IdW-1:0]    gnt_id
);

  int unsigned    idx;
  logic [IdW-1:0] sel;
  logic           found;

  // Scan from ptr upward with wrap and stop at the first asserted request.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    sel    = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = (32'(ptr) + i) % NumReq;
      sel = IdW'(idx);
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        gnt_id   = sel;
      end
    end
  end

endmodule

// File: rtl/seq_arbiter.sv
// Round-robin front end sharing one sequential multiply/divide engine.
module seq_arbiter
  import seq_pkg::*;
#(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned WidthA        = 32,
  parameter int unsigned WidthB        = 32,
  parameter int unsigned TimeoutCycles = 1024,
  localparam int unsigned WidthC       = prod_width(WidthA, WidthB),
  localparam int unsigned IdW          = id_width(NumReq)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumReq-1:0]              req_valid_i,
  output logic [NumReq-1:0]              req_ready_o,
  input  logic [NumReq-1:0][WidthA-1:0]  req_a_i,
  input  logic [NumReq-1:0][WidthB-1:0]  req_b_i,
  output logic [NumReq-1:0]              rsp_valid_o,
  input  logic [NumReq-1:0]              rsp_ready_i,
  output logic [WidthC-1:0]              rsp_c_o,
  output logic [WidthA-1:0]              rsp_q_o,
  output logic [WidthB-1:0]              rsp_r_o,
  output logic                           rsp_divz_o,
  output logic                           rsp_err_o,
  output logic [WidthA-1:0]              eng_a_o,
  output logic [WidthB-1:0]              eng_b_o,
  output logic                           eng_start_o,
  input  logic [WidthC-1:0]              eng_c_i,
  input  logic [WidthA-1:0]              eng_q_i,
  input  logic [WidthB-1:0]              eng_r_i,
  input  logic                           eng_finish_i,
  output logic                           busy_o
);

  localparam int unsigned TmrW = id_width(TimeoutCycles);

  seq_arb_state_e    state_q, state_d;
  logic [NumReq-1:0] gnt;
  logic [IdW-1:0]    gnt_id;
  logic [IdW-1:0]    ptr_q;
  logic [IdW-1:0]    id_q;
  logic [WidthA-1:0] a_q;
  logic [WidthB-1:0] b_q;
  logic              divz_q;
  logic              finish_d;
  logic [TmrW-1:0]   timer_q;
  logic              accept;
  logic              done;
  logic              expire;

  rr_arbiter #(.NumReq(NumReq)) u_rr (
    .req    (req_valid_i),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign accept  = (state_q == IDLE) && (gnt != '0);
  // Only a rising finish counts, so a level left high by a previous op is ignored.
  assign done    = (state_q == BUSY) && eng_finish_i && !finish_d;
  assign expire  = (state_q == BUSY) && (timer_q == TmrW'(TimeoutCycles - 1));
  assign eng_a_o = a_q;
  assign eng_b_o = b_q;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; completion takes priority over timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = BUSY;
      BUSY:    if (done || expire) state_d = RESP;
      RESP:    if (rsp_ready_i[id_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status decode; ready is held low while reset is asserted.
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    eng_start_o = 1'b0;
    busy_o      = (state_q != IDLE);
    unique case (state_q)
      IDLE:    if (rst_ni) req_ready_o = gnt;
      ISSUE:   eng_start_o = 1'b1;
      RESP:    rsp_valid_o[id_q] = 1'b1;
      default: ;
    endcase
  end

  // Operand latch, pointer, timer and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      divz_q     <= 1'b0;
      finish_d   <= 1'b0;
      timer_q    <= '0;
      rsp_c_o    <= '0;
      rsp_q_o    <= '0;
      rsp_r_o    <= '0;
      rsp_divz_o <= 1'b0;
      rsp_err_o  <= 1'b0;
    end else begin
      finish_d <= eng_finish_i;
      if (accept) begin
        a_q    <= req_a_i[gnt_id];
        b_q    <= req_b_i[gnt_id];
        id_q   <= gnt_id;
        divz_q <= (req_b_i[gnt_id] == '0);
        ptr_q  <= (gnt_id == IdW'(NumReq - 1)) ? '0 : gnt_id + IdW'(1);
      end
      if (state_q == ISSUE) timer_q <= '0;
      if (state_q == BUSY) begin
        timer_q <= timer_q + TmrW'(1);
        if (done) begin
          rsp_c_o    <= eng_c_i;
          rsp_q_o    <= eng_q_i;
          rsp_r_o    <= eng_r_i;
          rsp_divz_o <= divz_q;
          rsp_err_o  <= 1'b0;
        end else if (expire) begin
          rsp_c_o    <= '0;
          rsp_q_o    <= '0;
          rsp_r_o    <= '0;
          rsp_divz_o <= divz_q;
          rsp_err_o  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_arbiter.sv
// Directed bench for seq_arbiter with a small behavioural engine model.
module tb_seq_arbiter;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        req_valid;
  logic [3:0]        req_ready;
  logic [3:0][31:0]  req_a;
  logic [3:0][31:0]  req_b;
  logic [3:0]        rsp_valid;
  logic [3:0]        rsp_ready;
  logic [63:0]       rsp_c;
  logic [31:0]       rsp_q;
  logic [31:0]       rsp_r;
  logic              rsp_divz;
  logic              rsp_err;
  logic [31:0]       eng_a;
  logic [31:0]       eng_b;
  logic              eng_start;
  logic              busy;
  logic              eng_finish;

  logic [63:0]       m_c;
  logic [31:0]       m_q, m_r, ma, mb;
  logic              m_fin;
  int                m_cnt;
  bit                stub_fin;

  int n_checks = 0;
  int n_pass   = 0;
  int k;
  int cyc;

  always #5 clk = ~clk;

  seq_arbiter #(
    .NumReq(4), .WidthA(32), .WidthB(32), .TimeoutCycles(16)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_c_o      (rsp_c),
    .rsp_q_o      (rsp_q),
    .rsp_r_o      (rsp_r),
    .rsp_divz_o   (rsp_divz),
    .rsp_err_o    (rsp_err),
    .eng_a_o      (eng_a),
    .eng_b_o      (eng_b),
    .eng_start_o  (eng_start),
    .eng_c_i      (m_c),
    .eng_q_i      (m_q),
    .eng_r_i      (m_r),
    .eng_finish_i (eng_finish),
    .busy_o       (busy)
  );

  // Engine model: finish rises three cycles after start and stays high until the next start.
  assign eng_finish = stub_fin | m_fin;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fin <= 1'b0; m_cnt <= 0; ma <= '0; mb <= '0;
      m_c <= '0; m_q <= '0; m_r <= '0;
    end else if (eng_start) begin
      ma <= eng_a; mb <= eng_b; m_cnt <= 3; m_fin <= 1'b0;
    end else if (m_cnt == 1) begin
      m_cnt <= 0;
      m_fin <= 1'b1;
      m_c   <= {32'd0, ma} * {32'd0, mb};
      m_q   <= (mb != 0) ? ma / mb : 32'hFFFF_FFFF;
      m_r   <= (mb != 0) ? ma % mb : ma;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Wait (bounded) for a grant; returns the granted index and the negedges waited.
  task automatic wait_grant(input bit drop, output int id, output int waited);
    bit got = 1'b0;
    id = -1;
    waited = 0;
    while (!got && waited < 64) begin
      @(negedge clk);
      waited++;
      if (req_ready != 4'b0000) begin
        got = 1'b1;
        for (int j = 0; j < 4; j++) if (req_ready[j]) id = j;
      end
    end
    check("grant_seen", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    if (drop && id >= 0) req_valid[id] = 1'b0;
  endtask

  // Wait (bounded) for any response valid, sampled on negedges.
  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid == 4'b0000 && n < 64);
    check("rsp_seen", 64'(rsp_valid != 4'b0000), 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 4'b1111;
    stub_fin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 4'b1111; stub_fin = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_start", 64'(eng_start), 64'd0);
    check("rst_c", rsp_c, 64'd0);
    do_reset();

    // Single op: r0 6*3, 6/3
    req_a[0] = 32'd6; req_b[0] = 32'd3; req_valid[0] = 1'b1;
    wait_grant(1'b1, k, cyc);
    check("single_gnt", 64'(k), 64'd0);
    @(negedge clk);
    check("single_start", 64'(eng_start), 64'd1);
    check("single_eng_a", 64'(eng_a), 64'd6);
    check("single_eng_b", 64'(eng_b), 64'd3);
    check("single_ready_low", 64'(req_ready), 64'd0);
    wait_rsp(cyc);
    check("single_latency", 64'(cyc), 64'd5);
    check("single_valid", 64'(rsp_valid), 64'b0001);
    check("single_c", rsp_c, 64'd18);
    check("single_q", 64'(rsp_q), 64'd2);
    check("single_r", 64'(rsp_r), 64'd0);
    check("single_divz", 64'(rsp_divz), 64'd0);
    check("single_err", 64'(rsp_err), 64'd0);
    @(negedge clk);
    check("single_idle", 64'(busy), 64'd0);

    // Fairness from a fresh pointer: all four valid continuously
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[i] = 32'(100 + i); req_b[i] = 32'd7;
    end
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(1'b0, k, cyc);
      check("fair_gnt", 64'(k), 64'(i % 4));
      wait_rsp(cyc);
      check("fair_valid", 64'(rsp_valid), 64'(4'b0001 << (i % 4)));
      check("fair_q", 64'(rsp_q), 64'd14);
      check("fair_r", 64'(rsp_r), 64'(2 + (i % 4)));
      check("fair_c", rsp_c, 64'((100 + (i % 4)) * 7));
      if (i == 4) req_valid = '0;
    end

    // Backpressure: r3 response held while r1 waits; foreign ready bits ignored
    rsp_ready = 4'b0111;
    req_a[3] = 32'd9; req_b[3] = 32'd4; req_valid[3] = 1'b1;
    wait_grant(1'b1, k, cyc);
    check("bp_gnt", 64'(k), 64'd3);
    wait_rsp(cyc);
    req_a[1] = 32'd20; req_b[1] = 32'd6; req_valid[1] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", 64'(rsp_valid), 64'b1000);
      check("bp_c", rsp_c, 64'd36);
      check("bp_qr", {rsp_q, rsp_r}, {32'd2, 32'd1});
      check("bp_ready_low", 64'(req_ready), 64'd0);
      check("bp_no_start", 64'(eng_start), 64'd0);
    end
    rsp_ready = 4'b1111;
    wait_grant(1'b1, k, cyc);
    check("bp_next_gnt", 64'(k), 64'd1);
    check("bp_idle_wait", 64'(cyc), 64'd1);
    wait_rsp(cyc);
    check("bp_r1_valid", 64'(rsp_valid), 64'b0010);
    check("bp_r1_c", rsp_c, 64'd120);
    check("bp_r1_qr", {rsp_q, rsp_r}, {32'd3, 32'd2});

    // Divide by zero on r2
    req_a[2] = 32'd5; req_b[2] = 32'd0; req_valid[2] = 1'b1;
    wait_grant(1'b1, k, cyc);
    check("dz_gnt", 64'(k), 64'd2);
    wait_rsp(cyc);
    check("dz_valid", 64'(rsp_valid), 64'b0100);
    check("dz_c", rsp_c, 64'd0);
    check("dz_divz", 64'(rsp_divz), 64'd1);
    check("dz_q", 64'(rsp_q), 64'hFFFF_FFFF);
    check("dz_r", 64'(rsp_r), 64'd5);
    check("dz_err", 64'(rsp_err), 64'd0);

    // Timeout: finish stuck high, no rising edge ever seen
    stub_fin = 1'b1;
    req_a[0] = 32'd7; req_b[0] = 32'd2; req_valid[0] = 1'b1;
    wait_grant(1'b1, k, cyc);
    check("to_gnt", 64'(k), 64'd0);
    @(negedge clk);
    check("to_start", 64'(eng_start), 64'd1);
    wait_rsp(cyc);
    check("to_busy_cycles", 64'(cyc - 1), 64'd16);
    check("to_valid", 64'(rsp_valid), 64'b0001);
    check("to_err", 64'(rsp_err), 64'd1);
    check("to_c", rsp_c, 64'd0);
    check("to_qr", {rsp_q, rsp_r}, 64'd0);
    @(negedge clk);
    check("to_idle", 64'(busy), 64'd0);
    stub_fin = 1'b0;

    // Reset in BUSY discards the op and restarts the pointer at 0
    req_a[1] = 32'd3; req_b[1] = 32'd3; req_valid[1] = 1'b1;
    wait_grant(1'b1, k, cyc);
    check("rb_gnt", 64'(k), 64'd1);
    @(negedge clk);
    @(negedge clk);
    check("rb_in_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rb_busy", 64'(busy), 64'd0);
    check("rb_start", 64'(eng_start), 64'd0);
    check("rb_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rb_eng_a", 64'(eng_a), 64'd0);
    check("rb_err", 64'(rsp_err), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    req_a[1] = 32'd11; req_b[1] = 32'd4;
    req_a[3] = 32'd13; req_b[3] = 32'd5;
    req_valid[1] = 1'b1; req_valid[3] = 1'b1;
    wait_grant(1'b1, k, cyc);
    check("rb_first_gnt", 64'(k), 64'd1);
    wait_rsp(cyc);
    check("rb_r1_valid", 64'(rsp_valid), 64'b0010);
    check("rb_r1_c", rsp_c, 64'd44);
    check("rb_r1_qr", {rsp_q, rsp_r}, {32'd2, 32'd3});
    wait_grant(1'b1, k, cyc);
    check("rb_second_gnt", 64'(k), 64'd3);
    wait_rsp(cyc);
    check("rb_r3_valid", 64'(rsp_valid), 64'b1000);
    check("rb_r3_c", rsp_c, 64'd65);
    check("rb_r3_qr", {rsp_q, rsp_r}, {32'd2, 32'd3});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
